// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, iteration count and the signedness decode.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used both as absolute value on the
// operands and as the final sign correction on the results.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // negate when requested, pass through otherwise
    always_comb begin
        if (negate) begin
            result = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, sign fixed when committing.
module mdu_iter
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    mdu_state_e  state_r;
    logic        signed_r;
    logic        load_r;
    logic [31:0] src1_r;
    logic [31:0] src2_r;
    logic [4:0]  count_r;
    logic [63:0] acc_r;
    logic        busy_r;
    logic        done_r;
    logic        dbz_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        neg_a_s;
    logic        neg_b_s;
    logic        neg_res_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_diff_s;
    logic [63:0] mul_next_s;
    logic [63:0] div_next_s;
    logic [63:0] acc_next_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        last_s;

    assign neg_a_s   = signed_r & src1_r[31];
    assign neg_b_s   = signed_r & src2_r[31];
    assign neg_res_s = neg_a_s ^ neg_b_s;
    assign last_s    = (count_r == 5'(MDU_ITER - 1));

    mdu_sign_fix #(.WIDTH(32)) u_abs_a (.value(src1_r), .negate(neg_a_s), .result(abs_a_s));
    mdu_sign_fix #(.WIDTH(32)) u_abs_b (.value(src2_r), .negate(neg_b_s), .result(abs_b_s));

    // one multiply step and one restoring-divide step on the working register
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, abs_a_s} : 33'd0);
        mul_next_s = {mul_sum_s, acc_r[31:1]};
        // the borrow bit of the 33-bit trial subtract decides the quotient bit
        div_diff_s = acc_r[63:31] - {1'b0, abs_b_s};
        if (div_diff_s[32]) begin
            div_next_s = {acc_r[62:31], acc_r[30:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
        end
        if (state_r == ST_DIV) begin
            acc_next_s = div_next_s;
        end else begin
            acc_next_s = mul_next_s;
        end
    end

    mdu_sign_fix #(.WIDTH(64)) u_prod (.value(mul_next_s),         .negate(neg_res_s), .result(prod_fix_s));
    mdu_sign_fix #(.WIDTH(32)) u_quot (.value(div_next_s[31:0]),   .negate(neg_res_s), .result(quot_fix_s));
    mdu_sign_fix #(.WIDTH(32)) u_rem  (.value(div_next_s[63:32]),  .negate(neg_a_s),   .result(rem_fix_s));

    // select the signed-corrected result for the committing edge
    always_comb begin
        if (state_r == ST_DIV) begin
            res_hi_s = rem_fix_s;
            res_lo_s = quot_fix_s;
        end else begin
            res_hi_s = prod_fix_s[63:32];
            res_lo_s = prod_fix_s[31:0];
        end
    end

    // control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            signed_r <= 1'b0;
            load_r   <= 1'b0;
            src1_r   <= 32'd0;
            src2_r   <= 32'd0;
            count_r  <= 5'd0;
            acc_r    <= 64'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    dbz_r  <= 1'b0;
                    if (start && !cancel) begin
                        signed_r <= op_is_signed(op);
                        src1_r   <= src1;
                        src2_r   <= src2;
                        count_r  <= 5'd0;
                        busy_r   <= 1'b1;
                        if (!op[1]) begin
                            state_r <= ST_MUL;
                            load_r  <= 1'b1;
                        end else if (src2 != 32'd0) begin
                            state_r <= ST_DIV;
                            load_r  <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            load_r  <= 1'b0;
                            hi_r    <= src1;
                            lo_r    <= 32'hFFFF_FFFF;
                            done_r  <= 1'b1;
                            dbz_r   <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        load_r  <= 1'b0;
                        count_r <= 5'd0;
                    end else if (load_r) begin
                        // first busy cycle loads the operand magnitudes
                        load_r <= 1'b0;
                        if (state_r == ST_MUL) begin
                            acc_r <= {32'd0, abs_b_s};
                        end else begin
                            acc_r <= {32'd0, abs_a_s};
                        end
                    end else begin
                        acc_r   <= acc_next_s;
                        count_r <= count_r + 5'd1;
                        if (last_s) begin
                            state_r <= ST_DONE;
                            hi_r    <= res_hi_s;
                            lo_r    <= res_lo_s;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    dbz_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    dbz_r   <= 1'b0;
                    load_r  <= 1'b0;
                    count_r <= 5'd0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule
